// File: rtl/mult_err_accum.sv
// mult_err_accum
//   Error-metric accumulator that sits directly behind a 16x16 approximate
//   multiplier. Each accepted sample carries the operands and the approximate
//   product. The block recomputes the exact product in a three-stage pipeline
//   and accumulates the error statistics of one run of num_samples samples.
//
// Ports
//   clk, rst_n    single rising-edge clock, asynchronous active-low reset
//   start         run request, sampled only in IDLE
//   num_samples   samples per run, latched on an accepted start
//   in_valid      sample present on a, b, p_approx
//   in_ready      block accepts a sample this cycle (registered)
//   a, b          unsigned 16-bit operands
//   p_approx      approximate product under test
//   busy          run in progress (RUN or DRAIN)
//   done          one-cycle pulse, results are final
//   err_sum       sum of |a*b - p_approx|
//   err_max       largest |a*b - p_approx|
//   err_count     number of samples with a nonzero error
//   sample_count  samples accumulated in the current or last run
//
// ACC_W must be at least 32+CNT_W, which makes err_sum overflow impossible.
module mult_err_accum #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        a,
  input  logic [15:0]        b,
  input  logic [31:0]        p_approx,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   err_sum,
  output logic [31:0]        err_max,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   sample_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Absolute difference of two unsigned 32-bit values.
  function automatic logic [31:0] abs_diff32(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    if (x >= y) begin
      r = x - y;
    end else begin
      r = y - x;
    end
    return r;
  endfunction

  // Larger of two unsigned 32-bit values.
  function automatic logic [31:0] max32(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    if (x >= y) begin
      r = x;
    end else begin
      r = y;
    end
    return r;
  endfunction

  // Control state
  state_t             state_r;
  logic [CNT_W-1:0]   n_r;
  logic [CNT_W-1:0]   accepted_r;
  logic               in_ready_r;
  logic               busy_r;
  logic               done_r;

  // Pipeline state
  logic               s1_valid_r;
  logic [15:0]        s1_a_r;
  logic [15:0]        s1_b_r;
  logic [31:0]        s1_p_r;
  logic               s2_valid_r;
  logic [31:0]        s2_exact_r;
  logic [31:0]        s2_p_r;

  // Result registers
  logic [ACC_W-1:0]   err_sum_r;
  logic [31:0]        err_max_r;
  logic [CNT_W-1:0]   err_count_r;
  logic [CNT_W-1:0]   sample_count_r;

  // Combinational helpers
  logic               start_ok_s;
  logic               accept_s;
  logic [CNT_W-1:0]   accepted_nxt_s;
  logic [31:0]        exact_s;
  logic [31:0]        diff_s;
  logic               err_flag_s;

  // Handshake decode, accept-count look-ahead and the error datapath.
  always_comb begin
    start_ok_s     = 1'b0;
    accept_s       = 1'b0;
    accepted_nxt_s = accepted_r;
    exact_s        = 32'd0;
    diff_s         = 32'd0;
    err_flag_s     = 1'b0;

    if ((state_r == ST_IDLE) && start) begin
      start_ok_s = 1'b1;
    end else begin
      start_ok_s = 1'b0;
    end

    // in_ready_r is only ever set while in RUN, so it alone qualifies the accept.
    accept_s       = in_valid && in_ready_r;
    accepted_nxt_s = accepted_r + {{(CNT_W-1){1'b0}}, accept_s};

    exact_s    = {16'd0, s1_a_r} * {16'd0, s1_b_r};
    diff_s     = abs_diff32(s2_exact_r, s2_p_r);
    err_flag_s = (diff_s != 32'd0);
  end

  // Run control FSM with registered in_ready, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      n_r        <= {CNT_W{1'b0}};
      accepted_r <= {CNT_W{1'b0}};
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_ok_s) begin
            n_r        <= num_samples;
            accepted_r <= {CNT_W{1'b0}};
            if (num_samples != {CNT_W{1'b0}}) begin
              state_r    <= ST_RUN;
              busy_r     <= 1'b1;
              in_ready_r <= 1'b1;
            end else begin
              // Empty run: nothing to drain, report immediately.
              state_r    <= ST_DONE;
              busy_r     <= 1'b0;
              in_ready_r <= 1'b0;
              done_r     <= 1'b1;
            end
          end else begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end
        end
        ST_RUN: begin
          accepted_r <= accepted_nxt_s;
          // Look ahead one accept so in_ready drops the cycle after the last one.
          if (accepted_nxt_s == n_r) begin
            state_r    <= ST_DRAIN;
            in_ready_r <= 1'b0;
          end else begin
            state_r    <= ST_RUN;
            in_ready_r <= 1'b1;
          end
          busy_r <= 1'b1;
          done_r <= 1'b0;
        end
        ST_DRAIN: begin
          in_ready_r <= 1'b0;
          // With S1 empty, whatever sits in S2 is committed on this same edge.
          if (!s1_valid_r) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          in_ready_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 captures the accepted sample; stage 2 holds the exact product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= 16'd0;
      s1_b_r     <= 16'd0;
      s1_p_r     <= 32'd0;
      s2_valid_r <= 1'b0;
      s2_exact_r <= 32'd0;
      s2_p_r     <= 32'd0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r <= a;
        s1_b_r <= b;
        s1_p_r <= p_approx;
      end else begin
        s1_a_r <= s1_a_r;
        s1_b_r <= s1_b_r;
        s1_p_r <= s1_p_r;
      end

      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_exact_r <= exact_s;
        s2_p_r     <= s1_p_r;
      end else begin
        s2_exact_r <= s2_exact_r;
        s2_p_r     <= s2_p_r;
      end
    end
  end

  // Stage 3: clear on an accepted start, otherwise fold in each valid sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum_r      <= {ACC_W{1'b0}};
      err_max_r      <= 32'd0;
      err_count_r    <= {CNT_W{1'b0}};
      sample_count_r <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      err_sum_r      <= {ACC_W{1'b0}};
      err_max_r      <= 32'd0;
      err_count_r    <= {CNT_W{1'b0}};
      sample_count_r <= {CNT_W{1'b0}};
    end else if (s2_valid_r) begin
      err_sum_r      <= err_sum_r + {{(ACC_W-32){1'b0}}, diff_s};
      err_max_r      <= max32(err_max_r, diff_s);
      err_count_r    <= err_count_r + {{(CNT_W-1){1'b0}}, err_flag_s};
      sample_count_r <= sample_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_sum_r      <= err_sum_r;
      err_max_r      <= err_max_r;
      err_count_r    <= err_count_r;
      sample_count_r <= sample_count_r;
    end
  end

  assign in_ready     = in_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err_sum      = err_sum_r;
  assign err_max      = err_max_r;
  assign err_count    = err_count_r;
  assign sample_count = sample_count_r;

endmodule

// File: tb/tb_mult_err_accum.sv
// tb_mult_err_accum
//   Directed self-checking bench for mult_err_accum. Each task drives one
//   scenario and compares outputs against hand-computed values.
module tb_mult_err_accum;

  localparam int CNT_W = 16;
  localparam int ACC_W = 48;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [CNT_W-1:0]   num_samples;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        a;
  logic [15:0]        b;
  logic [31:0]        p_approx;
  logic               busy;
  logic               done;
  logic [ACC_W-1:0]   err_sum;
  logic [31:0]        err_max;
  logic [CNT_W-1:0]   err_count;
  logic [CNT_W-1:0]   sample_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] ta [8];
  logic [15:0] tbv[8];
  logic [31:0] tp [8];

  mult_err_accum #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .p_approx(p_approx),
    .busy(busy), .done(done), .err_sum(err_sum), .err_max(err_max),
    .err_count(err_count), .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed cnt samples from the tables, then wait (bounded) for done.
  task automatic drive(input int cnt, output int last_acc, output int done_at);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    last_acc = -100;
    done_at = -1;
    while (idx < cnt && guard < 200) begin
      a = ta[idx]; b = tbv[idx]; p_approx = tp[idx]; in_valid = 1'b1;
      if (in_ready) begin
        last_acc = cyc;
        idx++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    while (!done && guard < 200) begin
      tick();
      guard++;
    end
    if (done) done_at = cyc;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0h exp 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h exp 0", done); end
    checks++; if (err_sum !== 48'd0) begin errors++; $display("FAIL reset_err_sum got %0h exp 0", err_sum); end
    checks++; if (err_max !== 32'd0) begin errors++; $display("FAIL reset_err_max got %0h exp 0", err_max); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0h exp 0", err_count); end
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL reset_sample_count got %0h exp 0", sample_count); end
  endtask

  task automatic test_exact();
    int last;
    int dn;
    ta[0] = 16'd3;      tbv[0] = 16'd5;   tp[0] = 32'd15;
    ta[1] = 16'd7;      tbv[1] = 16'd9;   tp[1] = 32'd63;
    ta[2] = 16'd255;    tbv[2] = 16'd255; tp[2] = 32'd65025;
    ta[3] = 16'hFFFF;   tbv[3] = 16'd1;   tp[3] = 32'h0000FFFF;
    start = 1'b1; num_samples = 16'd4;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exact_busy_t1 got %0h exp 1", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL exact_ready_t1 got %0h exp 1", in_ready); end
    drive(4, last, dn);
    checks++; if (dn - last !== 3) begin errors++; $display("FAIL exact_latency got %0d exp 3", dn - last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exact_busy_done got %0h exp 0", busy); end
    checks++; if (err_sum !== 48'd0) begin errors++; $display("FAIL exact_err_sum got %0h exp 0", err_sum); end
    checks++; if (err_max !== 32'd0) begin errors++; $display("FAIL exact_err_max got %0h exp 0", err_max); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL exact_err_count got %0h exp 0", err_count); end
    checks++; if (sample_count !== 16'd4) begin errors++; $display("FAIL exact_sample_count got %0h exp 4", sample_count); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL exact_done_pulse got %0h exp 0", done); end
  endtask

  task automatic test_known_errors();
    int last;
    int dn;
    ta[0] = 16'd3;      tbv[0] = 16'd5;      tp[0] = 32'd14;
    ta[1] = 16'd100;    tbv[1] = 16'd200;    tp[1] = 32'd20010;
    ta[2] = 16'hFFFF;   tbv[2] = 16'hFFFF;   tp[2] = 32'd0;
    start = 1'b1; num_samples = 16'd3;
    tick();
    start = 1'b0;
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL known_clear_on_start got %0h exp 0", sample_count); end
    drive(3, last, dn);
    checks++; if (dn - last !== 3) begin errors++; $display("FAIL known_latency got %0d exp 3", dn - last); end
    checks++; if (err_sum !== 48'h0000FFFE000C) begin errors++; $display("FAIL known_err_sum got %0h exp fffe000c", err_sum); end
    checks++; if (err_max !== 32'hFFFE0001) begin errors++; $display("FAIL known_err_max got %0h exp fffe0001", err_max); end
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL known_err_count got %0h exp 3", err_count); end
    checks++; if (sample_count !== 16'd3) begin errors++; $display("FAIL known_sample_count got %0h exp 3", sample_count); end
    // A start in the DONE cycle must be ignored.
    start = 1'b1; num_samples = 16'd1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL known_start_in_done_busy got %0h exp 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL known_start_in_done_ready got %0h exp 0", in_ready); end
    checks++; if (sample_count !== 16'd3) begin errors++; $display("FAIL known_hold_after_done got %0h exp 3", sample_count); end
    tick();
  endtask

  task automatic test_backpressure();
    start = 1'b1; num_samples = 16'd2;
    tick();
    start = 1'b0;
    // c1: valid sample, exact
    a = 16'd1; b = 16'd1; p_approx = 32'd1; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_c1 got %0h exp 1", in_ready); end
    tick();
    // c2: gap
    in_valid = 1'b0;
    tick();
    // c3: valid sample, error 1 (last accept)
    a = 16'd2; b = 16'd3; p_approx = 32'd7; in_valid = 1'b1;
    tick();
    // c4: third valid must not be consumed
    a = 16'd10; b = 16'd10; p_approx = 32'd0; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_fall got %0h exp 0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_drain got %0h exp 1", busy); end
    tick();
    in_valid = 1'b0;
    tick();
    // c6 = last accept + 3
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done_c6 got %0h exp 1", done); end
    checks++; if (sample_count !== 16'd2) begin errors++; $display("FAIL bp_sample_count got %0h exp 2", sample_count); end
    checks++; if (err_sum !== 48'd1) begin errors++; $display("FAIL bp_err_sum got %0h exp 1", err_sum); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL bp_err_count got %0h exp 1", err_count); end
    tick();
  endtask

  task automatic test_zero_run();
    start = 1'b1; num_samples = 16'd0;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %0h exp 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_t1 got %0h exp 0", busy); end
    checks++; if (err_sum !== 48'd0) begin errors++; $display("FAIL zero_err_sum got %0h exp 0", err_sum); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL zero_err_count got %0h exp 0", err_count); end
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL zero_sample_count got %0h exp 0", sample_count); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_idle got done=%0h busy=%0h exp 0 0", done, busy); end
  endtask

  task automatic test_reset_mid_run();
    int last;
    int dn;
    start = 1'b1; num_samples = 16'd5;
    tick();
    start = 1'b0;
    a = 16'd4; b = 16'd4; p_approx = 32'd10; in_valid = 1'b1;
    tick();
    a = 16'd5; b = 16'd5; p_approx = 32'd20; in_valid = 1'b1;
    tick();
    // two accepted; assert reset away from the clock edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got %0h exp 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0h exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %0h exp 0", done); end
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL rst_mid_sample_count got %0h exp 0", sample_count); end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (err_sum !== 48'd0) begin errors++; $display("FAIL rst_mid_pipe_flushed got %0h exp 0", err_sum); end
    ta[0] = 16'd2; tbv[0] = 16'd2; tp[0] = 32'd5;
    start = 1'b1; num_samples = 16'd1;
    tick();
    start = 1'b0;
    drive(1, last, dn);
    checks++; if (dn - last !== 3) begin errors++; $display("FAIL rst_after_latency got %0d exp 3", dn - last); end
    checks++; if (err_sum !== 48'd1) begin errors++; $display("FAIL rst_after_err_sum got %0h exp 1", err_sum); end
    checks++; if (sample_count !== 16'd1) begin errors++; $display("FAIL rst_after_sample_count got %0h exp 1", sample_count); end
    tick();
  endtask

  task automatic test_start_while_busy();
    int acc;
    int guard;
    acc = 0;
    start = 1'b1; num_samples = 16'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 16'(i + 11); b = 16'(i + 3); p_approx = 32'((i + 11) * (i + 3)); in_valid = 1'b1;
      if (i == 1) begin
        start = 1'b1; num_samples = 16'd9;
      end else begin
        start = 1'b0;
      end
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b0;
    guard = 0;
    while (!done && guard < 50) begin
      tick();
      guard++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done got %0h exp 1", done); end
    checks++; if (acc !== 3) begin errors++; $display("FAIL busy_start_accepts got %0d exp 3", acc); end
    checks++; if (sample_count !== 16'd3) begin errors++; $display("FAIL busy_start_sample_count got %0h exp 3", sample_count); end
    checks++; if (err_sum !== 48'd0) begin errors++; $display("FAIL busy_start_err_sum got %0h exp 0", err_sum); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_samples = 16'd0;
    in_valid = 1'b0;
    a = 16'd0;
    b = 16'd0;
    p_approx = 32'd0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_exact();
    test_known_errors();
    test_backpressure();
    test_zero_run();
    test_reset_mid_run();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
